// File: rtl/matrix_pkg.sv
// Shared constants and types for the 8x8 LED matrix scan driver.
package matrix_pkg;

  localparam int MATRIX_ROWS   = 8;
  localparam int MATRIX_COLS   = 8;
  localparam int DEFAULT_DIV   = 6250;
  localparam int DEFAULT_BLANK = 16;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_phase_t;

endpackage

// File: rtl/slot_counter.sv
// Row-slot prescaler: counts clocks within a row slot and advances the row index on wrap.
module slot_counter #(
  parameter int DIV   = matrix_pkg::DEFAULT_DIV,
  parameter int BLANK = matrix_pkg::DEFAULT_BLANK,
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] o_cnt,
  output logic [2:0]    o_row_idx,
  output logic          o_wrap,
  output logic          o_blank_end
);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_rowIdx;
  logic          w_wrap;
  logic          w_blankEnd;

  // Strobes flag the upcoming edge so the top can compute next state without a pipeline stage.
  assign w_wrap     = (r_cnt == CW'(DIV - 1));
  assign w_blankEnd = (r_cnt == CW'(BLANK - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rowIdx <= 3'd0;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_rowIdx <= r_rowIdx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_row_idx   = r_rowIdx;
  assign o_wrap      = w_wrap;
  assign o_blank_end = w_blankEnd;

endmodule

// File: rtl/matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver with per-frame shadow capture and
// a blanking gap at the start of every row slot.
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int DIV            = DEFAULT_DIV,
  parameter int BLANK          = DEFAULT_BLANK,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  input  logic [7:0] data4,
  input  logic [7:0] data5,
  input  logic [7:0] data6,
  input  logic [7:0] data7,
  output logic [7:0] row,
  output logic [7:0] col,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [MATRIX_ROWS-1:0] ROW_POL = {MATRIX_ROWS{ROW_ACTIVE_LOW}};
  localparam logic [MATRIX_COLS-1:0] COL_POL = {MATRIX_COLS{COL_ACTIVE_LOW}};

  logic [CW-1:0]          w_cnt;
  logic [2:0]             w_rowIdx;
  logic                   w_wrap;
  logic                   w_blankEnd;
  logic [2:0]             w_rowNext;
  logic                   w_capture;
  logic [MATRIX_COLS-1:0] w_data       [MATRIX_ROWS];
  logic [MATRIX_COLS-1:0] w_shadowNext [MATRIX_ROWS];
  logic [MATRIX_ROWS-1:0] w_rowLogic;
  logic [MATRIX_COLS-1:0] w_colLogic;

  matrix_pkg::scan_phase_t r_phase;
  matrix_pkg::scan_phase_t w_phaseNext;
  logic [MATRIX_COLS-1:0]  r_shadow [MATRIX_ROWS];
  logic [MATRIX_ROWS-1:0]  r_row;
  logic [MATRIX_COLS-1:0]  r_col;
  logic                    r_frameTick;

  slot_counter #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_slot_counter (
    .clk         (clk),
    .reset       (reset),
    .o_cnt       (w_cnt),
    .o_row_idx   (w_rowIdx),
    .o_wrap      (w_wrap),
    .o_blank_end (w_blankEnd)
  );

  assign w_data[0] = data0;
  assign w_data[1] = data1;
  assign w_data[2] = data2;
  assign w_data[3] = data3;
  assign w_data[4] = data4;
  assign w_data[5] = data5;
  assign w_data[6] = data6;
  assign w_data[7] = data7;

  // Outputs are derived from next state so they line up with phase/row in the same cycle.
  always_comb begin
    w_phaseNext = r_phase;
    if (w_blankEnd) begin
      w_phaseNext = matrix_pkg::SHOW;
    end else if (w_wrap) begin
      w_phaseNext = matrix_pkg::BLANK;
    end
    w_rowNext = w_wrap ? (w_rowIdx + 3'd1) : w_rowIdx;
    w_capture = w_blankEnd && (w_rowIdx == 3'd0);
    for (int i = 0; i < MATRIX_ROWS; i++) begin
      w_shadowNext[i] = w_capture ? w_data[i] : r_shadow[i];
    end
    w_rowLogic = '0;
    w_colLogic = '0;
    if (w_phaseNext == matrix_pkg::SHOW) begin
      w_rowLogic = MATRIX_ROWS'(1) << w_rowNext;
      w_colLogic = w_shadowNext[w_rowNext];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= matrix_pkg::BLANK;
      r_row       <= ROW_POL;
      r_col       <= COL_POL;
      r_frameTick <= 1'b0;
      for (int i = 0; i < MATRIX_ROWS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_phase     <= w_phaseNext;
      r_row       <= w_rowLogic ^ ROW_POL;
      r_col       <= w_colLogic ^ COL_POL;
      r_frameTick <= w_capture;
      for (int i = 0; i < MATRIX_ROWS; i++) begin
        r_shadow[i] <= w_shadowNext[i];
      end
    end
  end

  assign row        = r_row;
  assign col        = r_col;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: three polarity variants run in lockstep on shared stimulus.
module tb_matrix_scan;

  localparam int DIV_T   = 8;
  localparam int BLANK_T = 2;
  localparam int FRAME_T = 8 * DIV_T;

  logic       clk;
  logic       reset;
  logic [7:0] data0, data1, data2, data3, data4, data5, data6, data7;
  logic [7:0] rowD, colD, rowN, colN, rowP, colP;
  logic       ftD, ftN, ftP;

  logic [7:0] tbData    [8];
  logic [7:0] expShadow [8];
  int nCompared;
  int nMismatched;

  // D: default polarity, N: both active-high, P: both active-low
  matrix_scan #(.DIV(DIV_T), .BLANK(BLANK_T), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)) dutD (
    .clk(clk), .reset(reset),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .row(rowD), .col(colD), .frame_tick(ftD));

  matrix_scan #(.DIV(DIV_T), .BLANK(BLANK_T), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)) dutN (
    .clk(clk), .reset(reset),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .row(rowN), .col(colN), .frame_tick(ftN));

  matrix_scan #(.DIV(DIV_T), .BLANK(BLANK_T), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)) dutP (
    .clk(clk), .reset(reset),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .row(rowP), .col(colP), .frame_tick(ftP));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    data0 = tbData[0]; data1 = tbData[1]; data2 = tbData[2]; data3 = tbData[3];
    data4 = tbData[4]; data5 = tbData[5]; data6 = tbData[6]; data7 = tbData[7];
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] expRow(int pos, int slot, bit activeLow);
    logic [7:0] v;
    v = (pos < BLANK_T) ? 8'h00 : (8'h01 << slot);
    return activeLow ? ~v : v;
  endfunction

  function automatic logic [7:0] expCol(int pos, int slot, bit activeLow);
    logic [7:0] v;
    v = (pos < BLANK_T) ? 8'h00 : expShadow[slot];
    return activeLow ? ~v : v;
  endfunction

  task automatic checkInactive(input string tag);
    checkOutput({tag, " rowD"}, rowD, 8'h00);
    checkOutput({tag, " colD"}, colD, 8'hFF);
    checkOutput({tag, " rowN"}, rowN, 8'h00);
    checkOutput({tag, " colN"}, colN, 8'h00);
    checkOutput({tag, " rowP"}, rowP, 8'hFF);
    checkOutput({tag, " colP"}, colP, 8'hFF);
    checkOutput({tag, " ft"},   {7'd0, ftN}, 8'h00);
  endtask

  // One frame starting at slot position 0 of row 0; frameNo selects the scenario events.
  task automatic runFrame(input int frameNo);
    int slot, pos;
    string t;
    for (int c = 0; c < FRAME_T; c++) begin
      slot = c / DIV_T;
      pos  = c % DIV_T;
      if (c == BLANK_T) begin
        for (int i = 0; i < 8; i++) expShadow[i] = tbData[i];
      end
      t = $sformatf("f%0d c%0d", frameNo, c);
      checkOutput({t, " rowD"}, rowD, expRow(pos, slot, 1'b0));
      checkOutput({t, " colD"}, colD, expCol(pos, slot, 1'b1));
      checkOutput({t, " rowN"}, rowN, expRow(pos, slot, 1'b0));
      checkOutput({t, " colN"}, colN, expCol(pos, slot, 1'b0));
      checkOutput({t, " rowP"}, rowP, expRow(pos, slot, 1'b1));
      checkOutput({t, " colP"}, colP, expCol(pos, slot, 1'b1));
      checkOutput({t, " ftN"}, {7'd0, ftN}, (c == BLANK_T) ? 8'h01 : 8'h00);
      checkOutput({t, " ftD"}, {7'd0, ftD}, (c == BLANK_T) ? 8'h01 : 8'h00);

      if (frameNo == 1 && c == 26) checkOutput("tear old row3", colN, 8'h82);
      if (frameNo == 2 && c == 26) checkOutput("tear new row3", colN, 8'h81);
      if (frameNo == 2 && c == 40) begin
        checkOutput("pol blank rowP", rowP, 8'hFF);
        checkOutput("pol blank colP", colP, 8'hFF);
      end
      if (frameNo == 2 && c == 42) begin
        checkOutput("pol show rowP", rowP, 8'hDF);
        checkOutput("pol show colP", colP, 8'hF0);
      end
      if (frameNo == 3 && c == 2)  checkOutput("race row0", colN, 8'h18);
      if (frameNo == 3 && c == 10) checkOutput("race row1", colN, 8'h24);
      if (frameNo == 5 && c == 2) begin
        checkOutput("restart row", rowN, 8'h01);
        checkOutput("restart col", colN, 8'h11);
      end

      // Row 2 showing: change data3 and data5, must not appear until next frame
      if (frameNo == 1 && c == 19) begin
        tbData[3] = 8'h81;
        tbData[5] = 8'h0F;
        applyStimulus();
      end
      // Cycle BLANK-1 of row 0: change lands right before the capture edge
      if (frameNo == 3 && c == BLANK_T - 1) begin
        tbData = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h81, 8'h42, 8'h24, 8'h18};
        applyStimulus();
      end
      // Row 6 showing: asynchronous reset mid-slot, then restart with a new image
      if (frameNo == 4 && c == 52) begin
        #2 reset = 1'b1;
        #1 checkInactive("midreset async");
        @(negedge clk);
        @(negedge clk);
        checkInactive("midreset held");
        tbData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    tbData      = '{8'h3C, 8'h42, 8'h89, 8'h82, 8'h84, 8'h82, 8'h41, 8'h3E};
    for (int i = 0; i < 8; i++) expShadow[i] = 8'h00;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkInactive("reset");
    reset = 1'b0;
    runFrame(1);
    runFrame(2);
    runFrame(3);
    runFrame(4);
    runFrame(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
